// File: rtl/dm_arbiter.sv
// Two-requester round-robin front end for a single-port 32-bit word memory with byte/half lanes.
// Writes take IDLE->CMD (2 cycles) and reads IDLE->CMD->RESP (3 cycles); requesters hold req until gnt.
module dm_arbiter #(
    parameter int DEPTH = 3072
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [1:0]  a_width,
    output logic        a_gnt,
    output logic        a_err,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [1:0]  b_width,
    output logic        b_gnt,
    output logic        b_err,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,

    output logic        m_en,
    output logic        m_we,
    output logic [11:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    logic [1:0]  state_q, state_d;
    logic        last_b_q, last_b_d;
    logic        sel_b_q, sel_b_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  width_q, width_d;

    logic        pick_b;
    logic        is_byte, is_half, is_word;
    logic        cmd_err;
    logic        in_cmd, in_resp;
    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic [31:0] rd_shift;
    logic [31:0] rd_c;

    assign pick_b = b_req & (~a_req | ~last_b_q);

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        sel_b_d  = sel_b_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        width_d  = width_q;
        case (state_q)
            IDLE: begin
                if (a_req | b_req) begin
                    state_d = CMD;
                    sel_b_d = pick_b;
                    we_d    = pick_b ? b_we    : a_we;
                    addr_d  = pick_b ? b_addr  : a_addr;
                    wdata_d = pick_b ? b_wdata : a_wdata;
                    width_d = pick_b ? b_width : a_width;
                end
            end
            CMD: begin
                // Fairness pointer moves on every grant, error grants included.
                last_b_d = sel_b_q;
                state_d  = (cmd_err | we_q) ? IDLE : RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            sel_b_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            width_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            sel_b_q  <= sel_b_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            width_q  <= width_d;
        end
    end

    // Width code 2'b11 is reserved and treated as a word access.
    assign is_byte = (width_q == 2'b10);
    assign is_half = (width_q == 2'b01);
    assign is_word = ~is_byte & ~is_half;

    assign cmd_err = (is_word & (addr_q[1:0] != 2'b00))
                   | (is_half & addr_q[0])
                   | (addr_q[31:2] >= DEPTH_W);

    always_comb begin
        be_c = 4'b1111;
        wd_c = wdata_q;
        if (is_byte) begin
            be_c = 4'b0001 << addr_q[1:0];
            wd_c = {4{wdata_q[7:0]}};
        end else if (is_half) begin
            be_c = addr_q[1] ? 4'b1100 : 4'b0011;
            wd_c = {2{wdata_q[15:0]}};
        end
    end

    // Half accesses are 2-byte aligned, so the byte-lane shift also serves halves.
    assign rd_shift = m_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        rd_c = m_rdata;
        if (is_byte) begin
            rd_c = {24'b0, rd_shift[7:0]};
        end else if (is_half) begin
            rd_c = {16'b0, rd_shift[15:0]};
        end
    end

    // All outputs decode from state_q, so an async reset clears them at once.
    assign in_cmd  = (state_q == CMD);
    assign in_resp = (state_q == RESP);

    assign a_gnt    = in_cmd & ~sel_b_q;
    assign b_gnt    = in_cmd &  sel_b_q;
    assign a_err    = a_gnt & cmd_err;
    assign b_err    = b_gnt & cmd_err;
    assign a_rvalid = in_resp & ~sel_b_q;
    assign b_rvalid = in_resp &  sel_b_q;
    assign a_rdata  = a_rvalid ? rd_c : 32'b0;
    assign b_rdata  = b_rvalid ? rd_c : 32'b0;

    assign m_en    = in_cmd & ~cmd_err;
    assign m_we    = m_en & we_q;
    assign m_addr  = m_en ? addr_q[13:2] : 12'b0;
    assign m_be    = m_en ? be_c : 4'b0;
    assign m_wdata = m_en ? wd_c : 32'b0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed requests push expected output cycles, a negedge monitor checks them.
module tb_dm_arbiter;

    logic        clk;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [1:0]  a_width, b_width;
    logic        a_gnt, a_err, a_rvalid, b_gnt, b_err, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        m_en, m_we;
    logic [11:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata, m_rdata;

    typedef struct packed {
        logic        a_gnt;
        logic        a_err;
        logic        a_rvalid;
        logic [31:0] a_rdata;
        logic        b_gnt;
        logic        b_err;
        logic        b_rvalid;
        logic [31:0] b_rdata;
        logic        m_en;
        logic        m_we;
        logic [11:0] m_addr;
        logic [3:0]  m_be;
        logic [31:0] m_wdata;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    dm_arbiter #(.DEPTH(3072)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_width(a_width),
        .a_gnt(a_gnt), .a_err(a_err), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_width(b_width),
        .b_gnt(b_gnt), .b_err(b_err), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.a_gnt = a_gnt;   o.a_err = a_err;   o.a_rvalid = a_rvalid; o.a_rdata = a_rdata;
        o.b_gnt = b_gnt;   o.b_err = b_err;   o.b_rvalid = b_rvalid; o.b_rdata = b_rdata;
        o.m_en  = m_en;    o.m_we  = m_we;    o.m_addr   = m_addr;
        o.m_be  = m_be;    o.m_wdata = m_wdata;
        return o;
    endfunction

    function automatic obs_t ev_gnt(input bit is_b, input bit err, input bit we,
                                    input logic [11:0] ma, input logic [3:0] be,
                                    input logic [31:0] wd);
        obs_t o = '0;
        if (is_b) begin o.b_gnt = 1'b1; o.b_err = err; end
        else      begin o.a_gnt = 1'b1; o.a_err = err; end
        o.m_en = ~err; o.m_we = we; o.m_addr = ma; o.m_be = be; o.m_wdata = wd;
        return o;
    endfunction

    function automatic obs_t ev_rv(input bit is_b, input logic [31:0] rd);
        obs_t o = '0;
        if (is_b) begin o.b_rvalid = 1'b1; o.b_rdata = rd; end
        else      begin o.a_rvalid = 1'b1; o.a_rdata = rd; end
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (a_gnt | b_gnt | a_rvalid | b_rvalid | m_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got %h expected none", sample());
            end else begin
                check("output_cycle", sample(), exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; holds req until gnt, then releases and idles one cycle.
    task automatic do_req(input bit is_b, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] width,
                          input logic [31:0] rd);
        bit got = 0;
        m_rdata = rd;
        if (is_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; b_width = width; end
        else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; a_width = width; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (is_b ? b_gnt : a_gnt) got = 1;
        end
        checks++;
        if (got) passes++;
        else $display("FAIL gnt_timeout: got no gnt expected gnt within 20 cycles");
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        int   ngnt;
        bit   got;
        reset = 0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_width = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_width = 0;
        m_rdata = 0;
        repeat (3) @(posedge clk);
        #3;
        check("reset_outputs", sample(), '0);
        reset = 1;
        @(posedge clk); #1;

        // Tie with both held for three writes: A, B, A.
        exp_q.push_back(ev_gnt(0, 0, 1, 12'h008, 4'hF, 32'h11111111));
        exp_q.push_back(ev_gnt(1, 0, 1, 12'h009, 4'hF, 32'h22222222));
        exp_q.push_back(ev_gnt(0, 0, 1, 12'h008, 4'hF, 32'h11111111));
        a_req = 1; a_we = 1; a_addr = 32'h20; a_wdata = 32'h11111111; a_width = 2'b00;
        b_req = 1; b_we = 1; b_addr = 32'h24; b_wdata = 32'h22222222; b_width = 2'b00;
        ngnt = 0;
        for (int i = 0; i < 40 && ngnt < 3; i++) begin
            @(negedge clk);
            if (a_gnt | b_gnt) ngnt++;
        end
        checks++;
        if (ngnt == 3) passes++;
        else $display("FAIL tie_grants: got %0d grants expected 3", ngnt);
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
        @(posedge clk); #1;

        exp_q.push_back(ev_gnt(0, 0, 0, 12'h004, 4'hF, 32'h0));
        exp_q.push_back(ev_rv(0, 32'hDEADBEEF));
        do_req(0, 0, 32'h10, 32'h0, 2'b00, 32'hDEADBEEF);

        exp_q.push_back(ev_gnt(1, 0, 1, 12'h001, 4'b1000, 32'hABABABAB));
        do_req(1, 1, 32'h7, 32'h000000AB, 2'b10, 32'h0);

        exp_q.push_back(ev_gnt(1, 0, 0, 12'h001, 4'b1100, 32'h0));
        exp_q.push_back(ev_rv(1, 32'h00008001));
        do_req(1, 0, 32'h6, 32'h0, 2'b01, 32'h8001FFFF);

        exp_q.push_back(ev_gnt(0, 0, 1, 12'h000, 4'b1100, 32'h12341234));
        do_req(0, 1, 32'h2, 32'h00001234, 2'b01, 32'h0);

        exp_q.push_back(ev_gnt(0, 0, 0, 12'h000, 4'b0010, 32'h0));
        exp_q.push_back(ev_rv(0, 32'h00000033));
        do_req(0, 0, 32'h1, 32'h0, 2'b10, 32'h11223344);

        exp_q.push_back(ev_gnt(1, 0, 0, 12'hBFF, 4'hF, 32'h0));
        exp_q.push_back(ev_rv(1, 32'hCAFEF00D));
        do_req(1, 0, 32'h2FFC, 32'h0, 2'b00, 32'hCAFEF00D);

        exp_q.push_back(ev_gnt(0, 0, 1, 12'h002, 4'hF, 32'h5A5A0000));
        do_req(0, 1, 32'h8, 32'h5A5A0000, 2'b11, 32'h0);

        exp_q.push_back(ev_gnt(1, 0, 0, 12'hBFF, 4'b1000, 32'h0));
        exp_q.push_back(ev_rv(1, 32'h00000080));
        do_req(1, 0, 32'h2FFF, 32'h0, 2'b10, 32'h80000000);

        // Error grants: misaligned word, out-of-range word, odd half.
        exp_q.push_back(ev_gnt(0, 1, 0, 12'h0, 4'h0, 32'h0));
        do_req(0, 0, 32'h2, 32'h0, 2'b00, 32'h12345678);
        exp_q.push_back(ev_gnt(0, 1, 0, 12'h0, 4'h0, 32'h0));
        do_req(0, 0, 32'h3000, 32'h0, 2'b00, 32'h12345678);
        exp_q.push_back(ev_gnt(1, 1, 0, 12'h0, 4'h0, 32'h0));
        do_req(1, 0, 32'h5, 32'h0, 2'b01, 32'h12345678);

        // A request pulse that falls before any edge must be ignored.
        a_req = 1; a_we = 0; a_addr = 32'h40; a_width = 2'b00;
        #2 a_req = 0;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a read response.
        exp_q.push_back(ev_gnt(0, 0, 0, 12'h004, 4'hF, 32'h0));
        m_rdata = 32'h0BADF00D;
        a_req = 1; a_we = 0; a_addr = 32'h10; a_wdata = 0; a_width = 2'b00;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (a_gnt) got = 1;
        end
        checks++;
        if (got) passes++;
        else $display("FAIL rst_gnt_timeout: got no gnt expected gnt within 20 cycles");
        @(posedge clk); #1;
        a_req = 0;
        #1 reset = 0;
        #1;
        check("reset_mid_resp", sample(), '0);
        repeat (2) @(negedge clk);
        check("reset_held", sample(), '0);
        @(posedge clk); #3;
        reset = 1;

        // First tie after reset goes to A.
        exp_q.push_back(ev_gnt(0, 0, 1, 12'h008, 4'hF, 32'h11111111));
        a_req = 1; a_we = 1; a_addr = 32'h20; a_wdata = 32'h11111111; a_width = 2'b00;
        b_req = 1; b_we = 1; b_addr = 32'h24; b_wdata = 32'h22222222; b_width = 2'b00;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (a_gnt | b_gnt) got = 1;
        end
        checks++;
        if (got) passes++;
        else $display("FAIL post_reset_gnt_timeout: got no gnt expected gnt within 20 cycles");
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
        repeat (4) @(posedge clk);
        #1;

        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter: DEPTH, 3072, number of 32-bit words behind the arbiter.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports for requester A: a_req in 1, a_we in 1, a_addr in 32 (byte address), a_wdata in 32, a_width in 2 (00 word, 01 half, 10 byte, 11 reserved = word).
REQ-005 SHALL have response ports for requester A: a_gnt out 1, a_err out 1, a_rvalid out 1, a_rdata out 32.
REQ-006 SHALL have the same request and response port set for requester B, named with the b_ prefix.
REQ-007 SHALL have memory-side ports: m_en out 1, m_we out 1, m_addr out 12 (word index), m_be out 4, m_wdata out 32, m_rdata in 32 (synchronous read, valid the cycle after m_en).

Function
REQ-008 SHALL run an FSM with states IDLE, CMD and RESP.
REQ-009 In IDLE with any req high, SHALL select one requester, register its command and enter CMD.
REQ-010 Arbitration SHALL be round-robin: if only one req is high, grant it; if both are high, grant the requester not served last.
REQ-011 The last-served flag SHALL reset to B, so A wins the first tie.
REQ-012 In CMD, SHALL pulse the winner's gnt for exactly 1 cycle; m_en, m_we, m_addr, m_be and m_wdata SHALL be valid that same cycle only.
REQ-013 Requesters SHALL hold req and all request fields stable until gnt; dropping req while in IDLE (before selection) SHALL be legal and SHALL have no effect.
REQ-014 Byte enables SHALL be: word = 1111; half = 0011 if addr[1]=0, else 1100; byte = one-hot of addr[1:0] (00 -> 0001 ... 11 -> 1000).
REQ-015 m_wdata SHALL replicate wdata[7:0] into all four lanes for byte accesses, wdata[15:0] into both halves for half accesses, and pass wdata unchanged for word accesses.
REQ-016 m_addr SHALL equal addr[13:2].
REQ-017 SHALL flag an error if a word access has addr[1:0]!=0, if a half access has addr[0]=1, or if addr[31:2] >= DEPTH.
REQ-018 On error, CMD SHALL assert gnt and err together for 1 cycle, keep m_en=0, produce no rvalid, and return to IDLE.
REQ-019 A write in CMD SHALL return the FSM to IDLE next cycle; a write is 2 cycles from the first IDLE-with-req to IDLE.
REQ-020 A read in CMD SHALL go to RESP next cycle; in RESP the winner's rvalid SHALL be high for 1 cycle, then the FSM returns to IDLE.
REQ-021 rdata SHALL be the selected lane(s) of m_rdata shifted to bit 0 and zero-extended (byte lane from addr[1:0], half lane from addr[1]), or all of m_rdata for a word read.
REQ-022 rdata SHALL be 0 whenever rvalid is low.
REQ-023 The last-served flag SHALL update in the CMD cycle, including error grants.
REQ-024 gnt, err and rvalid SHALL never be asserted toward both requesters in the same cycle.
REQ-025 Requests arriving in CMD or RESP SHALL wait; the arbiter SHALL re-arbitrate in the first IDLE cycle after the current access.

Reset
REQ-026 reset low SHALL immediately force the FSM to IDLE, the last-served flag to B, and all outputs to 0, regardless of clk.
REQ-027 A reset during CMD or RESP SHALL abort the access: no further gnt or rvalid for it, and m_en drops at once.
REQ-028 After reset is released, the first arbitration SHALL occur on the first rising clk edge with reset high.

Verification
REQ-029 A-only read word at 0x10 with m_rdata=0xDEADBEEF -> a_gnt, m_en=1, m_addr=4, m_be=1111 in CMD; next cycle a_rvalid=1, a_rdata=0xDEADBEEF.
REQ-030 A and B request simultaneously, both held for 3 accesses (writes) -> grant order A, B, A; never both gnt in one cycle.
REQ-031 B byte write, addr=0x7, wdata=0x000000AB -> m_be=1000, m_wdata=0xABABABAB, m_addr=1, m_we=1; half read at 0x6 with m_rdata=0x8001FFFF -> b_rdata=0x00008001.
REQ-032 A word read at 0x2 -> a_gnt=a_err=1 for 1 cycle, m_en=0, no a_rvalid; a read at addr=0x3000 (word 3072) -> a_err=1.
REQ-033 Assert reset low mid-RESP of a read -> a_rvalid stays 0, all outputs 0 immediately; after release, an A/B tie grants A.
